// File: rtl/systolic_skew_injector.sv
// -----------------------------------------------------------------------------
// systolic_skew_injector
//
// Purpose:
//     Multi-lane skew buffer that feeds one edge of a systolic PE array.
//     Each accepted N_LANES-wide vector is split into lanes, and lane i is
//     delayed by i pipeline advances. The result is the diagonal wavefront
//     the array expects. After VEC_LEN vectors, the block drains itself by
//     shifting in zero fill until the last vector's lane N_LANES-1 element
//     has been emitted. It then pulses o_frame_done for one cycle.
//     The pipeline only moves as a whole (on "advance"), so back-pressure
//     and input bubbles never break the alignment between lanes.
//
// Ports:
//     clk              in   clock
//     rst_n            in   asynchronous active-low reset
//     i_flush          in   synchronous clear of pipeline, counters and FSM
//     i_in_valid       in   input vector valid
//     o_in_ready       out  a vector can be accepted this cycle
//     i_in_data        in   input vector, lane i = [i*DATA_W +: DATA_W]
//     i_out_ready      in   array lets the pipeline advance this cycle
//     o_out_data       out  skewed lane outputs, same packing as i_in_data
//     o_out_lane_valid out  per-lane flag: lane holds real data, not fill
//     o_out_step       out  registered; outputs were updated on the last edge
//     o_frame_done     out  one-cycle pulse after the final drain advance
//     o_busy           out  FSM is not idle
// -----------------------------------------------------------------------------
module systolic_skew_injector #(
    parameter int DATA_W  = 16,
    parameter int N_LANES = 32,
    parameter int VEC_LEN = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_flush,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [N_LANES*DATA_W-1:0]   i_in_data,
    input  logic                        i_out_ready,
    output logic [N_LANES*DATA_W-1:0]   o_out_data,
    output logic [N_LANES-1:0]          o_out_lane_valid,
    output logic                        o_out_step,
    output logic                        o_frame_done,
    output logic                        o_busy
);

    localparam int IN_CNT_W    = $clog2(VEC_LEN + 1);
    localparam int DRAIN_CNT_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    localparam logic [IN_CNT_W-1:0]    IN_CNT_ONE  = IN_CNT_W'(1);
    localparam logic [IN_CNT_W-1:0]    IN_CNT_LAST = IN_CNT_W'(VEC_LEN - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD  = DRAIN_CNT_W'(N_LANES - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE   = DRAIN_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [IN_CNT_W-1:0]    r_inCnt;
    logic [IN_CNT_W-1:0]    w_inCntNext;
    logic [DRAIN_CNT_W-1:0] r_drainCnt;
    logic [DRAIN_CNT_W-1:0] w_drainCntNext;
    logic                   r_outStep;

    logic w_canAccept;
    logic w_accept;
    logic w_adv;

    // The whole pipeline moves only on an advance. No bubble is ever
    // inserted, so the relative delay between lanes is preserved.
    assign w_canAccept = (r_state == IDLE) || (r_state == STREAM);
    assign o_in_ready  = i_out_ready && w_canAccept;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_adv       = w_accept || (i_out_ready && (r_state == DRAIN));

    assign o_busy       = (r_state != IDLE);
    assign o_frame_done = (r_state == DONE);
    assign o_out_step   = r_outStep;

    // Next-state and counter logic. Terminal decisions are made on the
    // accept or advance that completes the phase, so the counters never wrap.
    always_comb begin
        w_stateNext    = r_state;
        w_inCntNext    = r_inCnt;
        w_drainCntNext = r_drainCnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_inCntNext = IN_CNT_ONE;
                    if (VEC_LEN == 1) begin
                        if (N_LANES == 1) begin
                            w_stateNext = DONE;
                        end else begin
                            w_stateNext    = DRAIN;
                            w_drainCntNext = DRAIN_LOAD;
                        end
                    end else begin
                        w_stateNext = STREAM;
                    end
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_inCntNext = r_inCnt + IN_CNT_ONE;
                    if (r_inCnt == IN_CNT_LAST) begin
                        if (N_LANES == 1) begin
                            w_stateNext = DONE;
                        end else begin
                            w_stateNext    = DRAIN;
                            w_drainCntNext = DRAIN_LOAD;
                        end
                    end
                end
            end
            DRAIN: begin
                if (w_adv) begin
                    w_drainCntNext = r_drainCnt - DRAIN_ONE;
                    if (r_drainCnt == DRAIN_ONE) begin
                        w_stateNext = DONE;
                    end
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inCnt    <= '0;
            r_drainCnt <= '0;
            r_outStep  <= 1'b0;
        end else if (i_flush) begin
            r_state    <= IDLE;
            r_inCnt    <= '0;
            r_drainCnt <= '0;
            r_outStep  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_inCnt    <= w_inCntNext;
            r_drainCnt <= w_drainCntNext;
            r_outStep  <= w_adv;
        end
    end

    // Lane gl is a chain of gl+1 stages, and its last stage drives the lane
    // output. Stage 0 takes the input lane on accept. It takes zero fill
    // (valid = 0) on drain advances, because w_accept is low in DRAIN.
    for (genvar gl = 0; gl < N_LANES; gl++) begin : g_lane
        logic [DATA_W-1:0] r_data [0:gl];
        logic [gl:0]       r_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= gl; k++) begin
                    r_data[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end
            end else if (i_flush) begin
                for (int k = 0; k <= gl; k++) begin
                    r_data[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end
            end else if (w_adv) begin
                r_data[0]  <= w_accept ? i_in_data[gl*DATA_W +: DATA_W] : '0;
                r_valid[0] <= w_accept;
                for (int k = 1; k <= gl; k++) begin
                    r_data[k]  <= r_data[k-1];
                    r_valid[k] <= r_valid[k-1];
                end
            end
        end

        assign o_out_data[gl*DATA_W +: DATA_W] = r_data[gl];
        assign o_out_lane_valid[gl]            = r_valid[gl];
    end

endmodule

// File: tb/tb_systolic_skew_injector.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_injector
//
// Purpose:
//     Self-checking bench for systolic_skew_injector. The main instance uses
//     N_LANES=4 and VEC_LEN=3. A second instance uses N_LANES=1 and
//     VEC_LEN=1 to cover the degenerate single-lane, single-vector frame.
//     Each lane has its own queue of expected {valid, data} entries. Lane i's
//     queue starts with i empty entries, so an entry pushed on an advance
//     comes out i advances later. Entries are popped whenever o_out_step is
//     expected.
// -----------------------------------------------------------------------------
module tb_systolic_skew_injector;

    localparam int DATA_W  = 16;
    localparam int N_LANES = 4;
    localparam int VEC_LEN = 3;
    localparam int MAX_CYC = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic                      flush;
    logic                      inValid;
    logic                      inReady;
    logic [N_LANES*DATA_W-1:0] inData;
    logic                      outReady;
    logic [N_LANES*DATA_W-1:0] outData;
    logic [N_LANES-1:0]        laneValid;
    logic                      outStep;
    logic                      frameDone;
    logic                      busy;

    logic                      cFlush;
    logic                      cInValid;
    logic                      cInReady;
    logic [DATA_W-1:0]         cInData;
    logic                      cOutReady;
    logic [DATA_W-1:0]         cOutData;
    logic [0:0]                cLaneValid;
    logic                      cOutStep;
    logic                      cFrameDone;
    logic                      cBusy;

    systolic_skew_injector #(
        .DATA_W (DATA_W),
        .N_LANES(N_LANES),
        .VEC_LEN(VEC_LEN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flush         (flush),
        .i_in_valid      (inValid),
        .o_in_ready      (inReady),
        .i_in_data       (inData),
        .i_out_ready     (outReady),
        .o_out_data      (outData),
        .o_out_lane_valid(laneValid),
        .o_out_step      (outStep),
        .o_frame_done    (frameDone),
        .o_busy          (busy)
    );

    systolic_skew_injector #(
        .DATA_W (DATA_W),
        .N_LANES(1),
        .VEC_LEN(1)
    ) dutCorner (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flush         (cFlush),
        .i_in_valid      (cInValid),
        .o_in_ready      (cInReady),
        .i_in_data       (cInData),
        .i_out_ready     (cOutReady),
        .o_out_data      (cOutData),
        .o_out_lane_valid(cLaneValid),
        .o_out_step      (cOutStep),
        .o_frame_done    (cFrameDone),
        .o_busy          (cBusy)
    );

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
    } entry_t;

    typedef enum {M_IDLE, M_STREAM, M_DRAIN, M_DONE} mstate_t;

    entry_t  laneQ [N_LANES][$];
    mstate_t mState;
    int      mInCnt;
    int      mDrainCnt;
    int      checkCount = 0;
    int      passCount  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [N_LANES*DATA_W-1:0] makeVec(input int base, input int t);
        logic [N_LANES*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_LANES; i++) begin
            v[i*DATA_W +: DATA_W] = DATA_W'(base + 10*t + i + 1);
        end
        return v;
    endfunction

    task automatic resetModel();
        entry_t e;
        e = '0;
        mState    = M_IDLE;
        mInCnt    = 0;
        mDrainCnt = 0;
        for (int i = 0; i < N_LANES; i++) begin
            laneQ[i].delete();
            for (int k = 0; k < i; k++) laneQ[i].push_back(e);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the combinational
    // outputs, then check the registered outputs 1 time unit after the
    // rising edge and update the model.
    task automatic applyStimulus(input logic v, input logic r, input logic fl,
                                 input logic [N_LANES*DATA_W-1:0] d,
                                 output logic accepted);
        logic   expReady;
        logic   adv;
        entry_t e;
        @(negedge clk);
        inValid  = v;
        outReady = r;
        flush    = fl;
        inData   = d;
        #1;
        expReady = r && (mState == M_IDLE || mState == M_STREAM);
        checkOutput("in_ready", inReady, expReady);
        checkOutput("busy", busy, mState != M_IDLE);
        accepted = v && expReady && !fl;
        adv      = !fl && r && ((expReady && v) || mState == M_DRAIN);
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (fl) begin
            resetModel();
            checkOutput("flush_step", outStep, 1'b0);
            checkOutput("flush_lane_valid", laneValid, '0);
            checkOutput("flush_data", outData, '0);
            checkOutput("flush_frame_done", frameDone, 1'b0);
        end else begin
            checkOutput("out_step", outStep, adv);
            if (adv) begin
                for (int i = 0; i < N_LANES; i++) begin
                    e.v = accepted;
                    e.d = accepted ? d[i*DATA_W +: DATA_W] : '0;
                    laneQ[i].push_back(e);
                    e = laneQ[i].pop_front();
                    checkOutput($sformatf("lane%0d_valid", i), laneValid[i], e.v);
                    checkOutput($sformatf("lane%0d_data", i), outData[i*DATA_W +: DATA_W], e.d);
                end
                case (mState)
                    M_IDLE, M_STREAM: begin
                        mInCnt = (mState == M_IDLE) ? 1 : mInCnt + 1;
                        if (mInCnt == VEC_LEN) begin
                            mState    = M_DRAIN;
                            mDrainCnt = N_LANES - 1;
                        end else begin
                            mState = M_STREAM;
                        end
                    end
                    M_DRAIN: begin
                        mDrainCnt--;
                        if (mDrainCnt == 0) mState = M_DONE;
                    end
                    default: ;
                endcase
            end else if (mState == M_DONE) begin
                mState = M_IDLE;
            end
            checkOutput("frame_done", frameDone, mState == M_DONE);
        end
    endtask

    // Modes: 0 back-to-back, 1 out_ready toggling, 2 two-cycle input gaps,
    // 3 flush while two drain advances remain, 4 stop after two accepts.
    task automatic runFrame(input int base, input int mode);
        int   t;
        int   gap;
        int   cyc;
        logic acc;
        logic v;
        logic r;
        logic fl;
        bit   done;
        t    = 0;
        gap  = 0;
        cyc  = 0;
        done = 0;
        while (!done) begin
            r  = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            v  = (t < VEC_LEN) && (gap == 0);
            fl = (mode == 3) && (mState == M_DRAIN) && (mDrainCnt == 2);
            applyStimulus(v, r, fl, makeVec(base, (t < VEC_LEN) ? t : 0), acc);
            if (acc) begin
                t++;
                if (mode == 2) gap = 2;
            end else if (gap > 0) begin
                gap--;
            end
            cyc++;
            if (fl) done = 1;
            if (mode == 4 && t == 2) done = 1;
            if (mState == M_DONE) done = 1;
            if (!done && cyc >= MAX_CYC) begin
                checkOutput("frame_timeout", 1'b1, 1'b0);
                done = 1;
            end
        end
    endtask

    initial begin
        logic acc;
        rst_n     = 1'b0;
        flush     = 1'b0;
        inValid   = 1'b0;
        outReady  = 1'b1;
        inData    = '0;
        cFlush    = 1'b0;
        cInValid  = 1'b0;
        cOutReady = 1'b1;
        cInData   = '0;
        resetModel();

        #1;
        checkOutput("reset_in_ready", inReady, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_frame_done", frameDone, 1'b0);
        checkOutput("reset_step", outStep, 1'b0);
        checkOutput("reset_lane_valid", laneValid, '0);
        checkOutput("reset_data", outData, '0);

        @(negedge clk);
        rst_n = 1'b1;

        runFrame(0, 0);
        runFrame(100, 1);
        runFrame(200, 2);
        runFrame(300, 3);
        runFrame(400, 0);
        runFrame(500, 4);

        // Asynchronous reset in the middle of a frame, between clock edges.
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_lane_valid", laneValid, '0);
        checkOutput("async_data", outData, '0);
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_step", outStep, 1'b0);
        checkOutput("async_frame_done", frameDone, 1'b0);
        checkOutput("async_in_ready_lo", inReady, 1'b0);
        outReady = 1'b1;
        #1;
        checkOutput("async_in_ready_hi", inReady, 1'b1);
        rst_n = 1'b1;
        resetModel();

        runFrame(600, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, acc);

        // Single lane, single vector: one accept, then frame_done.
        @(negedge clk);
        cInValid = 1'b1;
        cInData  = 16'h1234;
        #1;
        checkOutput("c_in_ready_idle", cInReady, 1'b1);
        checkOutput("c_busy_idle", cBusy, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("c_step", cOutStep, 1'b1);
        checkOutput("c_data", cOutData, 16'h1234);
        checkOutput("c_lane_valid", cLaneValid, 1'b1);
        checkOutput("c_frame_done", cFrameDone, 1'b1);
        checkOutput("c_busy_done", cBusy, 1'b1);
        checkOutput("c_in_ready_done", cInReady, 1'b0);
        @(negedge clk);
        cInValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("c_frame_done_end", cFrameDone, 1'b0);
        checkOutput("c_busy_end", cBusy, 1'b0);
        checkOutput("c_step_end", cOutStep, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/systolic_skew_injector.md
Name: systolic_skew_injector

Overview:
- Parametrised multi-lane skew buffer feeding one edge (rows or columns) of the systolic array.
- Accepts one N_LANES-wide vector per handshake and delays lane i by i advances, producing the diagonal wavefront the PE grid needs.
- Frames of VEC_LEN vectors are followed by an automatic zero-fill drain; a one-cycle pulse marks frame completion.
- Handles back-pressure and bubbles while keeping lane alignment intact; supports synchronous flush.

Parameters:
- DATA_W, 16, element width in bits.
- N_LANES, 32, number of lanes (array rows or cols); must be >= 1.
- VEC_LEN, 32, vectors per frame (reduction length); must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of pipeline, counters and FSM.
- in_valid  in  1  input vector valid.
- in_ready  out  1  injector can accept a vector this cycle.
- in_data  in  N_LANES*DATA_W  input vector; lane i = bits [i*DATA_W +: DATA_W].
- out_ready  in  1  array permits the pipeline to advance this cycle.
- out_data  out  N_LANES*DATA_W  skewed lane outputs, same lane packing.
- out_lane_valid  out  N_LANES  per-lane flag: out_data lane holds real data, not zero fill.
- out_step  out  1  registered; high the cycle after an advance, meaning out_data/out_lane_valid were just updated.
- frame_done  out  1  one-cycle pulse after the final drain advance.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Storage: lane i is a chain of i+1 registers (stage 0..i), each holding data plus a valid bit. Lane i output = stage i. Total storage = N_LANES*(N_LANES+1)/2 entries.
- advance (adv) = out_ready && ((state in {IDLE, STREAM} && in_valid) || state == DRAIN). All chains shift only on adv. No bubbles are ever inserted, so skew is preserved under stalls.
- in_ready = out_ready && state in {IDLE, STREAM}. Accept = in_valid && in_ready, which equals adv outside DRAIN.
- On adv, stage 0 of every lane loads {in_data lane, 1} on accept, or {0, 0} in DRAIN; stage k loads stage k-1.
- Latency: a vector accepted at advance t appears on lane i after advance t+i, i.e. lane 0 the cycle after accept.
- FSM and counters:
  - IDLE: on accept, in_cnt <= 1, go to STREAM; if VEC_LEN == 1, go to DRAIN instead (or DONE if N_LANES == 1).
  - STREAM: on accept, in_cnt++. On the accept with in_cnt == VEC_LEN-1, load drain_cnt <= N_LANES-1 and go to DRAIN (DONE if N_LANES == 1).
  - DRAIN: on each adv, drain_cnt--. On the adv with drain_cnt == 1, go to DONE. Zero fill guarantees the lane N_LANES-1 tail of the last vector is emitted.
  - DONE: frame_done = 1 for exactly this cycle; unconditionally go to IDLE. in_ready = 0 in DONE.
- Counter widths: in_cnt is clog2(VEC_LEN+1) bits; drain_cnt is clog2(N_LANES) bits (min 1); no wrap occurs in legal operation.
- out_step <= adv each cycle (registered).
- Reset (async, rst_n low, any time including mid-frame): all stages data/valid = 0, state = IDLE, counters = 0, out_step = 0, frame_done = 0. Derived outputs: in_ready = out_ready, busy = 0.
- flush (synchronous, highest priority over accept/adv): same clear as reset on the next edge. No frame_done is produced and the partial frame is discarded.
- out_ready low: nothing shifts, counters and state hold. in_valid may stay asserted with data held stable.
- in_valid low in STREAM with out_ready high: no advance (hold), because skew must not bubble.
- Simultaneous DONE and in_valid: not accepted; the vector is taken in IDLE next cycle.

Test Plan:
- N_LANES=4, VEC_LEN=3, out_ready=1, back-to-back vectors with lane i of vector t = 10*t+i+1 -> after advance 1 lane0=1; after advance 3 lane2=3; lane3 shows 4,14,24 after advances 4,5,6. Drain takes 3 advances, frame_done pulses once in the cycle after the 6th advance, busy drops the next cycle.
- Same stimulus with out_ready toggling 1,0,1,0 -> identical output sequence sampled on out_step, no lane skipped or duplicated, in_ready low whenever out_ready low.
- in_valid gaps of 2 cycles in STREAM -> out_step low during gaps, no zeros with out_lane_valid=1 ever emitted, skew unchanged.
- flush asserted during DRAIN (drain_cnt=2) -> next cycle all out_lane_valid=0, busy=0, no frame_done, new frame starts cleanly.
- rst_n pulsed low mid-STREAM, asynchronously between edges -> outputs zero immediately, in_ready follows out_ready.
- Corner configs: N_LANES=1, VEC_LEN=1 -> one accept then frame_done the next cycle. N_LANES=1, VEC_LEN=3 -> no DRAIN.
